// File: rtl/nfa_pkg.sv
// Shared types and constants for the parametrised one-hot NFA match engine.
package nfa_pkg;

    localparam int MAX_STATES = 64;
    localparam int DEF_POS_W  = 16;
    localparam int CNT_W      = 8;

    typedef logic [DEF_POS_W-1:0] pos_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // Payload phase: consuming bytes, closing out the last byte, or parked until sod.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LAST = 2'd1,
        ST_IDLE = 2'd2
    } eng_state_e;

    // Number of bits needed to index 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nfa_state_cell.sv
// One NFA state bit: loads hit & feed on each enabled byte, cleared by sod.
module nfa_state_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic sod,
    input  logic en,
    input  logic hit,
    input  logic feed,
    output logic q
);

    // State bit update; clear wins over advance.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (sod) begin
            q <= 1'b0;
        end else if (en) begin
            q <= hit & feed;
        end
    end

endmodule

// File: rtl/nfa_match_engine.sv
// Configurable one-hot NFA matcher with first-match offset, end-of-data done
// pulse and an optional saturating match counter (enabled by macro NFA_MATCH_COUNT_EN).
module nfa_match_engine
    import nfa_pkg::*;
#(
    parameter int                              N_STATES    = 32,
    parameter int                              N_CLASS     = 128,
    parameter int                              CLS_W       = 7,
    parameter logic [N_STATES*CLS_W-1:0]       STATE_CLASS = '0,
    parameter logic [N_STATES*N_STATES-1:0]    PRED        = '0,
    parameter logic [N_STATES-1:0]             START_MASK  = {{(N_STATES-1){1'b0}}, 1'b1},
    parameter logic [N_STATES-1:0]             FINAL_MASK  = '0,
    parameter int                              POS_W       = $bits(pos_t)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sod,
    input  logic               en,
    input  logic [N_CLASS-1:0] char_class,
    input  logic               eod,
    output logic               match,
    output logic [POS_W-1:0]   match_pos,
    output logic               done,
    output logic [CNT_W-1:0]   match_cnt
);

    // Elaboration-time sanity checks on the topology parameters.
    if (N_STATES < 2 || N_STATES > MAX_STATES) begin : g_bad_states
        $error("nfa_match_engine: N_STATES out of range 2..%0d", MAX_STATES);
    end
    if (CLS_W < clog2(N_CLASS)) begin : g_bad_cls_w
        $error("nfa_match_engine: CLS_W too narrow for N_CLASS");
    end

    eng_state_e          state_q, state_d;
    logic [N_STATES-1:0] s;
    logic [N_STATES-1:0] hit;
    logic [N_STATES-1:0] feed;
    logic [POS_W-1:0]    pos;
    logic                step_en;   // byte advances the NFA and the position
    logic                eval;      // registered state is examined for a match
    logic                flush;     // clear the NFA once the payload is closed
    logic                set_done;
    logic                any_final;

    assign any_final = |(s & FINAL_MASK);

    // One state cell per NFA state, fed by its predecessors and the root.
    for (genvar i = 0; i < N_STATES; i++) begin : g_state
        logic [CLS_W-1:0] cls_idx;
        assign cls_idx = STATE_CLASS[i*CLS_W +: CLS_W];
        assign hit[i]  = char_class[cls_idx];
        assign feed[i] = START_MASK[i] | (|(PRED[i*N_STATES +: N_STATES] & s));

        nfa_state_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .sod   (sod | flush),
            .en    (step_en),
            .hit   (hit[i]),
            .feed  (feed[i]),
            .q     (s[i])
        );
    end

    // Payload phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Phase sequencing: the byte after eod only closes out the payload.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        step_en  = 1'b0;
        eval     = 1'b0;
        flush    = 1'b0;
        set_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (en) begin
                    step_en = 1'b1;
                    eval    = 1'b1;
                    if (eod) state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (en) begin
                    eval     = 1'b1;
                    flush    = 1'b1;
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_IDLE: ;
            default: state_d = ST_RUN;
        endcase
        if (sod) state_d = ST_RUN;
    end

    // Byte position: counts consumed bytes, saturating instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (sod) begin
            pos <= '0;
        end else if (step_en && (pos != {POS_W{1'b1}})) begin
            pos <= pos + POS_W'(1);
        end
    end

    // Sticky match flag and the offset of the byte that completed the first match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match     <= 1'b0;
            match_pos <= '0;
        end else if (sod) begin
            match     <= 1'b0;
            match_pos <= '0;
        end else if (eval && any_final && !match) begin
            match     <= 1'b1;
            match_pos <= pos - POS_W'(1);
        end
    end

    // Single-cycle done pulse once the last byte has been evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   done <= 1'b0;
        else if (sod) done <= 1'b0;
        else          done <= set_done;
    end

`ifdef NFA_MATCH_COUNT_EN
    // Saturating count of evaluated bytes that left a final state active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (sod) begin
            match_cnt <= '0;
        end else if (eval && any_final && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/nfa_match_engine.md
Name: nfa_match_engine

Overview:
- Parametrised successor to the per-rule fixed-chain PCRE engines.
- One configurable one-hot NFA. Topology (predecessors, self-loops, start, final, per-state character class) is supplied as elaboration parameters, so one RTL module serves every rule and the rule compiler emits parameter values instead of per-rule modules.
- Sits behind the shared character-class decoder in the payload engine. Consumes one decoded byte per enabled cycle.
- Adds behaviour the fixed engines lack: a match-offset report, an end-of-data done handshake and an optional match counter.

Parameters:
- N_STATES, 32, number of NFA state bits (2..64).
- N_CLASS, 128, width of the decoded character-class bus.
- CLS_W, 7, width of a class index; must satisfy 2**CLS_W >= N_CLASS.
- STATE_CLASS, 0, packed N_STATES*CLS_W. Field i is the class index tested by state i.
- PRED, 0, packed N_STATES*N_STATES. Bit [i*N_STATES+j] set means state j feeds state i.
- START_MASK, 1, N_STATES. States fed by the always-active root (unanchored start).
- FINAL_MASK, 0, N_STATES. Accepting states.
- POS_W, 16, width of the byte-position counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sod  in  1  start of data; synchronous clear of all state, counters and flags.
- en  in  1  byte valid; all state advances only when en=1.
- char_class  in  N_CLASS  one-hot or multi-hot class hits for the current byte.
- eod  in  1  qualifies the byte on this en cycle as the last byte of the payload.
- match  out  1  sticky; set when any final state becomes active.
- match_pos  out  POS_W  0-based index of the byte that completed the first match.
- done  out  1  single-cycle pulse after the last byte is processed.
- match_cnt  out  8  optional; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous): state vector S=0, pos=0, match=0, match_pos=0, done=0, match_cnt=0.
- sod=1 (synchronous): same clear values as reset. sod has priority over en and eod in the same cycle, so that cycle's byte is discarded.
- Per en cycle, for each state i:
  - hit_i = char_class[STATE_CLASS[i]]
  - feed_i = START_MASK[i] | OR over j of (PRED[i][j] & S[j])
  - S[i] <= hit_i & feed_i
  - A self-loop is expressed as PRED[i][i]=1.
- en=0: S, pos and all flags hold; done is forced to 0.
- pos increments on every en cycle. It saturates at 2**POS_W-1 and does not wrap.
- Match detection uses the registered state: on the first cycle where (S & FINAL_MASK) != 0 and match=0:
  - match <= 1;
  - match_pos <= pos-1, the index of the byte that set S.
  - Later matches do not update match_pos.
- Latency: byte k accepted at edge t sets S at t; match and match_pos are visible after edge t+1.
- End of data: en & eod at edge t. Then done=1 after edge t+1, for exactly one cycle, with match and match_pos final on that same cycle.
  - After done, S is cleared and the engine idles until sod.
  - Further en cycles before sod are ignored.
- eod without en has no effect.
- Reset asserted mid-payload aborts immediately; no done pulse is produced.

Optional Feature:
- Macro NFA_MATCH_COUNT_EN.
- Defined: match_cnt counts en-qualified cycles where (S & FINAL_MASK) != 0. It saturates at 255 and is cleared by reset and sod. It is final on the done cycle.
- Undefined: match_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package nfa_pkg holds:
  - typedefs for the position and count types;
  - localparam MAX_STATES=64;
  - a constant function clog2 used for CLS_W checks.
- Elaboration-time assertions check CLS_W against N_CLASS and N_STATES <= MAX_STATES.
- Sub-module nfa_state_cell implements one state bit:
  - inputs hit, feed, en, sod, clk, rst_n;
  - output q;
  - generated N_STATES times.

Test Plan:
- Pattern a b+ c, with classes a=1, b=2, c=3 and START_MASK=001. Bytes "xabbbc" with eod on "c" -> match=1, match_pos=5, done pulse one cycle after "c"; with the feature, match_cnt=1.
- Same pattern, bytes "abd" with eod -> done=1, match=0, match_pos=0.
- Bytes "abcabc", with the counter enabled -> match_pos=2 (first match only), match_cnt=2.
- Toggle en=0 for 3 cycles between "a" and "b" of "abc" -> match_pos=2. S holds across the gap and done arrives one en cycle after "c".
- sod asserted together with en on byte "c" mid-match -> no match; pos=0 next cycle. Then rst_n pulsed low mid-payload -> all outputs 0 asynchronously and no done pulse.
- POS_W=4 with a 20-byte payload whose final byte completes the match -> match_pos=14, pos saturated at 15, no wrap.
